// File: rtl/pipe_pkg.sv
// Shared types for the decoded-control pipeline: stage bundles, bubble value,
// forwarding-select encodings and a register-match helper.
package pipe_pkg;

  localparam int unsigned AW  = 5;
  localparam int unsigned OPW = 5;

  typedef struct packed {
    logic [OPW-1:0] aluOp;
    logic           aluSrc;
    logic           regDst;
    logic           branch;
  } exCtrl_t;

  typedef struct packed {
    logic memRead;
    logic memWrite;
  } memCtrl_t;

  typedef struct packed {
    logic regWrite;
    logic memtoReg;
  } wbCtrl_t;

  typedef struct packed {
    exCtrl_t  ex;
    memCtrl_t mem;
    wbCtrl_t  wb;
  } ctrl_t;

  typedef struct packed {
    ctrl_t         ctrl;
    logic [AW-1:0] wdst;
  } idEx_t;

  typedef struct packed {
    memCtrl_t      mem;
    wbCtrl_t       wb;
    logic [AW-1:0] wdst;
  } exMem_t;

  typedef struct packed {
    wbCtrl_t       wb;
    logic [AW-1:0] wdst;
  } memWb_t;

  localparam ctrl_t BUBBLE = '0;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // A nonzero destination that matches either source; $0 never matches.
  function automatic logic srcMatch(input logic [AW-1:0] dst,
                                    input logic [AW-1:0] rs,
                                    input logic [AW-1:0] rt);
    return (dst != '0) && ((dst == rs) || (dst == rt));
  endfunction

  // Forward select for one operand; EX/MEM result is newer than MEM/WB.
  function automatic logic [1:0] fwdSel(input logic          memRegWrite,
                                        input logic [AW-1:0] memWdst,
                                        input logic          wbRegWrite,
                                        input logic [AW-1:0] wbWdst,
                                        input logic [AW-1:0] src);
    if (memRegWrite && (memWdst != '0) && (memWdst == src)) begin
      return FWD_EXMEM;
    end else if (wbRegWrite && (wbWdst != '0) && (wbWdst == src)) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: stall, IF/ID flush, ID/EX bubble select and
// (with CTRL_PIPE_FWD_EN) operand forwarding selects.
module hazard_unit
  import pipe_pkg::*;
(
  input  logic          reset,
  input  logic          idValid,
  input  logic          idJump,
  input  logic [AW-1:0] idRs,
  input  logic [AW-1:0] idRt,
  input  logic          exMemRead,
  input  logic [AW-1:0] exWdst,
  input  logic          memRegWrite,
  input  logic [AW-1:0] memWdst,
`ifdef CTRL_PIPE_FWD_EN
  input  logic [AW-1:0] exRs,
  input  logic [AW-1:0] exRt,
  input  logic          wbRegWrite,
  input  logic [AW-1:0] wbWdst,
  output logic [1:0]    forwardA,
  output logic [1:0]    forwardB,
`else
  input  logic          exRegWrite,
`endif
  input  logic          exBranchTaken,
  output logic          stall,
  output logic          flushIfid,
  output logic          idExBubble
);

  logic hz;

  // Dependence of the ID instruction on a result not yet available.
  always_comb begin
    hz = 1'b0;
    if (idValid) begin
      if (exMemRead && srcMatch(exWdst, idRs, idRt)) begin
        hz = 1'b1;
      end
`ifndef CTRL_PIPE_FWD_EN
      if (exRegWrite && srcMatch(exWdst, idRs, idRt)) begin
        hz = 1'b1;
      end
      if (memRegWrite && srcMatch(memWdst, idRs, idRt)) begin
        hz = 1'b1;
      end
`endif
    end
  end

  // Priority: taken branch > hazard stall > jump flush > normal advance.
  always_comb begin
    stall      = 1'b0;
    flushIfid  = 1'b0;
    idExBubble = 1'b0;
    if (!reset) begin
      if (exBranchTaken) begin
        flushIfid  = 1'b1;
        idExBubble = 1'b1;
      end else if (hz) begin
        stall      = 1'b1;
        idExBubble = 1'b1;
      end else begin
        idExBubble = !idValid;
        flushIfid  = idJump && idValid;
      end
    end
  end

`ifdef CTRL_PIPE_FWD_EN
  // Operand bypass selects for the instruction in EX.
  always_comb begin
    forwardA = fwdSel(memRegWrite, memWdst, wbRegWrite, wbWdst, exRs);
    forwardB = fwdSel(memRegWrite, memWdst, wbRegWrite, wbWdst, exRt);
  end
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control bundle from ID through ID/EX, EX/MEM and MEM/WB,
// inserting bubbles on load-use hazards and flushing on jump / taken branch.
// Build option: define CTRL_PIPE_FWD_EN to add the forwarding unit
// (forward_a/forward_b ports); otherwise RAW hazards stall until resolved.
module ctrl_pipe
  import pipe_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           id_valid,
  input  logic [AW-1:0]  id_rs,
  input  logic [AW-1:0]  id_rt,
  input  logic [AW-1:0]  id_rd,
  input  logic           id_jump,
  input  logic           id_branch,
  input  logic           id_MemRead,
  input  logic           id_MemtoReg,
  input  logic           id_MemWrite,
  input  logic           id_ALUSrc,
  input  logic           id_RegWrite,
  input  logic           id_RegDst,
  input  logic [OPW-1:0] id_AluOp,
  input  logic           ex_branch_taken,
  output logic           stall,
  output logic           flush_ifid,
  output logic [OPW-1:0] ex_AluOp,
  output logic           ex_ALUSrc,
  output logic           ex_RegDst,
  output logic           ex_branch,
  output logic [AW-1:0]  ex_wdst,
  output logic           mem_MemRead,
  output logic           mem_MemWrite,
  output logic [AW-1:0]  mem_wdst,
  output logic           wb_RegWrite,
  output logic           wb_MemtoReg,
`ifdef CTRL_PIPE_FWD_EN
  output logic [1:0]     forward_a,
  output logic [1:0]     forward_b,
`endif
  output logic [AW-1:0]  wb_wdst
);

  ctrl_t         idCtrl;
  logic [AW-1:0] idWdst;
  idEx_t         idEx;
  exMem_t        exMem;
  memWb_t        memWb;
  logic          idExBubble;

`ifdef CTRL_PIPE_FWD_EN
  logic [AW-1:0] exRs;
  logic [AW-1:0] exRt;
`endif

  // Assemble the incoming bundle from the decoder fields.
  always_comb begin
    idCtrl              = BUBBLE;
    idCtrl.ex.aluOp     = id_AluOp;
    idCtrl.ex.aluSrc    = id_ALUSrc;
    idCtrl.ex.regDst    = id_RegDst;
    idCtrl.ex.branch    = id_branch;
    idCtrl.mem.memRead  = id_MemRead;
    idCtrl.mem.memWrite = id_MemWrite;
    idCtrl.wb.regWrite  = id_RegWrite;
    idCtrl.wb.memtoReg  = id_MemtoReg;
    idWdst              = id_RegDst ? id_rd : id_rt;
  end

  hazard_unit uHazard (
    .reset         (reset),
    .idValid       (id_valid),
    .idJump        (id_jump),
    .idRs          (id_rs),
    .idRt          (id_rt),
    .exMemRead     (idEx.ctrl.mem.memRead),
    .exWdst        (idEx.wdst),
    .memRegWrite   (exMem.wb.regWrite),
    .memWdst       (exMem.wdst),
`ifdef CTRL_PIPE_FWD_EN
    .exRs          (exRs),
    .exRt          (exRt),
    .wbRegWrite    (memWb.wb.regWrite),
    .wbWdst        (memWb.wdst),
    .forwardA      (forward_a),
    .forwardB      (forward_b),
`else
    .exRegWrite    (idEx.ctrl.wb.regWrite),
`endif
    .exBranchTaken (ex_branch_taken),
    .stall         (stall),
    .flushIfid     (flush_ifid),
    .idExBubble    (idExBubble)
  );

  // ID/EX: the only stage that can take a bubble.
  always_ff @(posedge clk) begin
    if (reset || idExBubble) begin
      idEx.ctrl <= BUBBLE;
      idEx.wdst <= '0;
    end else begin
      idEx.ctrl <= idCtrl;
      idEx.wdst <= idWdst;
    end
  end

`ifdef CTRL_PIPE_FWD_EN
  // Source registers of the EX instruction, needed by the forwarding unit.
  always_ff @(posedge clk) begin
    if (reset || idExBubble) begin
      exRs <= '0;
      exRt <= '0;
    end else begin
      exRs <= id_rs;
      exRt <= id_rt;
    end
  end
`endif

  // EX/MEM and MEM/WB always shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      exMem <= '0;
      memWb <= '0;
    end else begin
      exMem.mem  <= idEx.ctrl.mem;
      exMem.wb   <= idEx.ctrl.wb;
      exMem.wdst <= idEx.wdst;
      memWb.wb   <= exMem.wb;
      memWb.wdst <= exMem.wdst;
    end
  end

  assign ex_AluOp     = idEx.ctrl.ex.aluOp;
  assign ex_ALUSrc    = idEx.ctrl.ex.aluSrc;
  assign ex_RegDst    = idEx.ctrl.ex.regDst;
  assign ex_branch    = idEx.ctrl.ex.branch;
  assign ex_wdst      = idEx.wdst;
  assign mem_MemRead  = exMem.mem.memRead;
  assign mem_MemWrite = exMem.mem.memWrite;
  assign mem_wdst     = exMem.wdst;
  assign wb_RegWrite  = memWb.wb.regWrite;
  assign wb_MemtoReg  = memWb.wb.memtoReg;
  assign wb_wdst      = memWb.wdst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: each issued ID slot pushes the bundle it
// should place in ID/EX; after every edge the last three entries are compared
// against the EX, MEM and WB outputs and the oldest is retired.
`timescale 1ns/1ps
module tb_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       jump;
    logic       branch;
    logic       memRead;
    logic       memtoReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic       regDst;
    logic [4:0] aluOp;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic [4:0] aluOp;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic [4:0] wdst;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memtoReg;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_jump, id_branch, id_MemRead, id_MemtoReg;
  logic       id_MemWrite, id_ALUSrc, id_RegWrite, id_RegDst;
  logic [4:0] id_rs, id_rt, id_rd, id_AluOp;
  logic       ex_branch_taken;
  logic       stall, flush_ifid;
  logic [4:0] ex_AluOp, ex_wdst, mem_wdst, wb_wdst;
  logic       ex_ALUSrc, ex_RegDst, ex_branch;
  logic       mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
`ifdef CTRL_PIPE_FWD_EN
  logic [1:0] forward_a, forward_b;
`endif

  int   nChecks = 0;
  int   nPass   = 0;
  exp_t sb[$];

  ctrl_pipe dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_jump         (id_jump),
    .id_branch       (id_branch),
    .id_MemRead      (id_MemRead),
    .id_MemtoReg     (id_MemtoReg),
    .id_MemWrite     (id_MemWrite),
    .id_ALUSrc       (id_ALUSrc),
    .id_RegWrite     (id_RegWrite),
    .id_RegDst       (id_RegDst),
    .id_AluOp        (id_AluOp),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .ex_AluOp        (ex_AluOp),
    .ex_ALUSrc       (ex_ALUSrc),
    .ex_RegDst       (ex_RegDst),
    .ex_branch       (ex_branch),
    .ex_wdst         (ex_wdst),
    .mem_MemRead     (mem_MemRead),
    .mem_MemWrite    (mem_MemWrite),
    .mem_wdst        (mem_wdst),
    .wb_RegWrite     (wb_RegWrite),
    .wb_MemtoReg     (wb_MemtoReg),
`ifdef CTRL_PIPE_FWD_EN
    .forward_a       (forward_a),
    .forward_b       (forward_b),
`endif
    .wb_wdst         (wb_wdst)
  );

  always #5 clk = ~clk;

  // Run-length guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      nPass++;
    end
  endtask

  function automatic instr_t nop();
    instr_t i = '0;
    return i;
  endfunction

  function automatic instr_t rtype(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [4:0] op);
    instr_t i = '0;
    i.valid = 1'b1; i.regWrite = 1'b1; i.regDst = 1'b1;
    i.aluOp = op; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t ld(input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.valid = 1'b1; i.memRead = 1'b1; i.memtoReg = 1'b1; i.regWrite = 1'b1;
    i.aluSrc = 1'b1; i.aluOp = 5'h01; i.rs = rs; i.rt = rt; i.rd = 5'd30;
    return i;
  endfunction

  function automatic instr_t br(input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.valid = 1'b1; i.branch = 1'b1; i.aluOp = 5'h02; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic instr_t jmp(input logic [4:0] rs);
    instr_t i = '0;
    i.valid = 1'b1; i.jump = 1'b1; i.rs = rs;
    return i;
  endfunction

  // Bundle a valid instruction should deposit in ID/EX.
  function automatic exp_t mkExp(input instr_t i);
    exp_t e = '0;
    e.aluOp = i.aluOp; e.aluSrc = i.aluSrc; e.regDst = i.regDst;
    e.branch = i.branch; e.wdst = i.regDst ? i.rd : i.rt;
    e.memRead = i.memRead; e.memWrite = i.memWrite;
    e.regWrite = i.regWrite; e.memtoReg = i.memtoReg;
    return e;
  endfunction

  task automatic drive(input instr_t i);
    id_valid = i.valid; id_jump = i.jump; id_branch = i.branch;
    id_MemRead = i.memRead; id_MemtoReg = i.memtoReg; id_MemWrite = i.memWrite;
    id_ALUSrc = i.aluSrc; id_RegWrite = i.regWrite; id_RegDst = i.regDst;
    id_AluOp = i.aluOp; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
  endtask

  // Compare EX/MEM/WB outputs with the newest three scoreboard entries.
  task automatic checkStages();
    int   n;
    exp_t e, m, w;
    n = sb.size();
    e = sb[n-1];
    m = sb[n-2];
    w = sb[n-3];
    checkVal("ex", 32'({ex_AluOp, ex_ALUSrc, ex_RegDst, ex_branch, ex_wdst}),
             32'({e.aluOp, e.aluSrc, e.regDst, e.branch, e.wdst}));
    checkVal("mem", 32'({mem_MemRead, mem_MemWrite, mem_wdst}),
             32'({m.memRead, m.memWrite, m.wdst}));
    checkVal("wb", 32'({wb_RegWrite, wb_MemtoReg, wb_wdst}),
             32'({w.regWrite, w.memtoReg, w.wdst}));
    void'(sb.pop_front());
  endtask

`ifdef CTRL_PIPE_FWD_EN
  task automatic checkFwd(input logic [1:0] a, input logic [1:0] b);
    checkVal("fwdA", 32'(forward_a), 32'(a));
    checkVal("fwdB", 32'(forward_b), 32'(b));
  endtask
`endif

  // One ID slot: check combinational stall/flush, push the expected ID/EX
  // bundle, clock, then check all stages.
  task automatic step(input instr_t i, input logic bt, input logic expStall, input logic expFlush);
    drive(i);
    ex_branch_taken = bt;
    #1;
    checkVal("stall", 32'(stall), 32'(expStall));
    checkVal("flush", 32'(flush_ifid), 32'(expFlush));
    if (!i.valid || expStall || bt) begin
      sb.push_back('0);
    end else begin
      sb.push_back(mkExp(i));
    end
    @(posedge clk);
    #1;
    checkStages();
  endtask

  task automatic drain();
    repeat (3) step(nop(), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    instr_t junk;

    // Reset with a valid jump in ID: nothing may leak out.
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    drive(jmp(5'd3));
    sb.push_back('0);
    sb.push_back('0);
    repeat (2) begin
      sb.push_back('0);
      @(posedge clk);
      #1;
      checkVal("rstStall", 32'(stall), 32'd0);
      checkVal("rstFlush", 32'(flush_ifid), 32'd0);
      checkStages();
`ifdef CTRL_PIPE_FWD_EN
      checkFwd(2'b00, 2'b00);
`endif
    end
    reset = 1'b0;

    // R-type rd=3 travels EX -> MEM -> WB.
    step(rtype(5'd1, 5'd2, 5'd3, 5'h01), 1'b0, 1'b0, 1'b0);
    drain();

    // Load r5 then use r5.
    step(ld(5'd1, 5'd5), 1'b0, 1'b0, 1'b0);
    step(rtype(5'd5, 5'd6, 5'd7, 5'h03), 1'b0, 1'b1, 1'b0);
`ifndef CTRL_PIPE_FWD_EN
    step(rtype(5'd5, 5'd6, 5'd7, 5'h03), 1'b0, 1'b1, 1'b0);
`endif
    step(rtype(5'd5, 5'd6, 5'd7, 5'h03), 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
    checkFwd(2'b01, 2'b00);
`endif
    drain();

    // ALU result r4 consumed immediately.
    step(rtype(5'd1, 5'd2, 5'd4, 5'h01), 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
    step(rtype(5'd4, 5'd2, 5'd8, 5'h02), 1'b0, 1'b0, 1'b0);
    checkFwd(2'b10, 2'b00);
`else
    step(rtype(5'd4, 5'd2, 5'd8, 5'h02), 1'b0, 1'b1, 1'b0);
    step(rtype(5'd4, 5'd2, 5'd8, 5'h02), 1'b0, 1'b1, 1'b0);
    step(rtype(5'd4, 5'd2, 5'd8, 5'h02), 1'b0, 1'b0, 1'b0);
`endif
    drain();

    // Branch reaches EX and resolves taken: ID instruction squashed.
    step(br(5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    step(rtype(5'd1, 5'd2, 5'd10, 5'h01), 1'b1, 1'b0, 1'b1);
    drain();

    // Taken branch overrides a pending load-use stall.
    step(ld(5'd1, 5'd9), 1'b0, 1'b0, 1'b0);
    step(rtype(5'd9, 5'd3, 5'd11, 5'h01), 1'b1, 1'b0, 1'b1);
    drain();

    // Plain jump: flush, no stall, its bundle enters EX.
    step(jmp(5'd0), 1'b0, 1'b0, 1'b1);
    drain();

    // Jump behind a dependent load: stall wins, flush follows once clear.
    step(ld(5'd1, 5'd5), 1'b0, 1'b0, 1'b0);
    step(jmp(5'd5), 1'b0, 1'b1, 1'b0);
`ifndef CTRL_PIPE_FWD_EN
    step(jmp(5'd5), 1'b0, 1'b1, 1'b0);
`endif
    step(jmp(5'd5), 1'b0, 1'b0, 1'b1);
    drain();

    // Writes to $0 never create hazards or forwards.
    step(rtype(5'd1, 5'd2, 5'd0, 5'h01), 1'b0, 1'b0, 1'b0);
    step(rtype(5'd0, 5'd0, 5'd11, 5'h04), 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
    checkFwd(2'b00, 2'b00);
`endif
    step(ld(5'd1, 5'd0), 1'b0, 1'b0, 1'b0);
    step(rtype(5'd0, 5'd3, 5'd12, 5'h01), 1'b0, 1'b0, 1'b0);
    drain();

    // Invalid slot with junk fields loads a bubble, no flush.
    junk = jmp(5'd11);
    junk.regWrite = 1'b1;
    junk.regDst = 1'b1;
    junk.rd = 5'd7;
    junk.aluOp = 5'h1f;
    junk.valid = 1'b0;
    step(junk, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset asserted while a stall is active.
    step(ld(5'd1, 5'd5), 1'b0, 1'b0, 1'b0);
    drive(rtype(5'd5, 5'd6, 5'd7, 5'h01));
    #1;
    checkVal("preRstStall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    checkVal("midRstStall", 32'(stall), 32'd0);
    checkVal("midRstFlush", 32'(flush_ifid), 32'd0);
    sb.delete();
    repeat (3) sb.push_back('0);
    @(posedge clk);
    #1;
    checkStages();
    checkVal("postRstStall", 32'(stall), 32'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decoded-control interface.
- Takes the control bundle produced by the opcode decoder in ID and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles; flushes on jump and taken branch.
- Delivers per-stage control signals and the writeback register address to the datapath.

Parameters:
- AW, 5, register-address width.
- OPW, 5, AluOp width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  AW  source register 1 of ID instruction
- id_rt  in  AW  source register 2 / I-type destination
- id_rd  in  AW  R-type destination
- id_jump, id_branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_RegDst  in  1 each  decoded control from decoder
- id_AluOp  in  OPW  decoded ALU operation
- ex_branch_taken  in  1  branch in EX resolved taken (from ALU zero & ex_branch)
- stall  out  1  hold PC and IF/ID (combinational)
- flush_ifid  out  1  zero the IF/ID register (combinational)
- ex_AluOp  out  OPW
- ex_ALUSrc, ex_RegDst, ex_branch  out  1 each
- ex_wdst  out  AW  RegDst ? rd : rt, registered at ID/EX
- mem_MemRead, mem_MemWrite  out  1 each
- mem_wdst  out  AW
- wb_RegWrite, wb_MemtoReg  out  1 each
- wb_wdst  out  AW
- forward_a, forward_b  out  2 each  present only with CTRL_PIPE_FWD_EN

Behaviour:
- Reset is synchronous. All stage registers clear to 0 (bubble), so every output is 0 after reset, including stall and flush_ifid.
- Bubble: all control bits 0, AluOp = 0, wdst = 0.
- Latency: a control bundle accepted in ID appears on ex_* the next cycle, on mem_* two cycles later and on wb_* three cycles later.
- id_valid = 0: a bubble is loaded into ID/EX.
- Load-use hazard (hz), all of the following true:
  - ex MemRead = 1
  - ex_wdst != 0
  - ex_wdst == id_rs, or ex_wdst == id_rt
  - id_valid = 1
- On hz:
  - stall = 1 for exactly one cycle.
  - A bubble is loaded into ID/EX.
  - EX/MEM and MEM/WB advance normally.
  - Next cycle the load sits in MEM, hz clears, and the ID instruction proceeds.
- Jump (id_jump & id_valid & !stall): flush_ifid = 1 and the jump's own bundle enters ID/EX. Jump has no RegWrite in this ISA subset.
- ex_branch_taken = 1:
  - flush_ifid = 1.
  - ID/EX loads a bubble, squashing the ID instruction.
  - stall is forced to 0, even if hz is true.
- Priority: ex_branch_taken > hz stall > jump flush > normal advance.
- Register $0 is never a hazard or forward source.
- Reset asserted mid-stall: all registers clear and stall deasserts the same cycle.
- The pipeline registers never hold; only ID/EX takes a bubble. EX/MEM and MEM/WB always shift.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN.
- Defined:
  - Forwarding unit compiled in.
  - forward_a: 2'b10 if mem RegWrite & mem_wdst != 0 & mem_wdst == ex_rs; else 2'b01 if wb_RegWrite & wb_wdst != 0 & wb_wdst == ex_rs; else 2'b00.
  - forward_b: same rule against ex_rt.
  - EX/MEM takes priority over MEM/WB.
  - ex_rs and ex_rt are stored in ID/EX.
  - Only load-use stalls.
- Undefined:
  - forward_* ports and ex_rs/ex_rt storage are absent.
  - hz is widened to also fire when ex or mem stage RegWrite = 1 with a nonzero wdst matching id_rs or id_rt.
  - Stall repeats each cycle until the hazard clears, so a dependence may take 1-2 stall cycles.

Decomposition:
- Shared package pipe_pkg:
  - ctrl bundle typedef: ex/mem/wb sub-structs.
  - BUBBLE constant.
  - FWD_REG / FWD_EXMEM / FWD_MEMWB encodings.
  - AW, OPW.
- One sub-module, hazard_unit: purely combinational. Computes stall, flush_ifid and forward_* from stage fields.
- ctrl_pipe owns the three stage registers.

Test Plan:
- Reset held 2 cycles, then id R-type (RegWrite = 1, RegDst = 1, AluOp = 5'h01, rd = 3) -> all outputs 0 during reset; ex_wdst = 3 at cycle +1, mem_wdst = 3 at +2, wb_RegWrite = 1 and wb_wdst = 3 at +3.
- Load (MemRead = 1, rt = 5) followed by add with rs = 5 -> stall = 1 for one cycle, ex_* all 0 the next cycle, add reaches EX one cycle late. With FWD_EN, forward_a = 2'b01 when add is in EX.
- add rd = 4, then sub rs = 4 (FWD_EN) -> no stall, forward_a = 2'b10. Without FWD_EN -> stall = 1 for 2 cycles.
- Branch in EX with ex_branch_taken = 1 while a load-use hazard is also pending -> flush_ifid = 1, stall = 0, next ex_* bubble.
- id_jump = 1 -> flush_ifid = 1 the same cycle, no stall, ex_branch = 0.
- Writes to $0 (rd = 0) followed by use of rs = 0 -> no stall, forward_a = 2'b00.
